// File: rtl/debug_node.sv
// Store-and-forward serial debug node: receives a frame, applies local read/write, retransmits it.
// Optional build macro SERIAL_DEBUG_BROADCAST_EN: write frames to address 15'h7FFF update every node.
module debug_node #(
   parameter int          BITS    = 128,
   parameter logic [14:0] ADDRESS = 15'h0001
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      prescaler,
   input  logic            debug_rx_data,
   input  logic            debug_rx_clk,
   output logic            debug_tx_data,
   output logic            debug_tx_clk,
   input  logic [BITS-1:0] debug_in,
   output logic [BITS-1:0] debug_out,
   output logic            debug_out_valid,
   output logic            busy
);

   localparam int SF_BITS = BITS + 16;
   localparam int CW      = $clog2(SF_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RX      = 2'd1,
      ST_PROCESS = 2'd2,
      ST_TX      = 2'd3
   } state_t;

   state_t               state_q;
   logic [2:0]           clk_sync_q;
   logic [1:0]           dat_sync_q;
   logic [SF_BITS-1:0]   frame_q;
   logic [CW-1:0]        bit_cnt_q;
   logic [CW-1:0]        tx_cnt_q;
   logic [7:0]           hp_cnt_q;
   logic                 tx_clk_q;
   logic                 tx_data_q;
   logic [BITS-1:0]      debug_out_q;
   logic                 debug_out_valid_q;
   logic                 busy_q;

   logic                 rx_rise_s;
   logic                 rx_bit_s;
   logic                 last_bit_s;
   logic                 frame_dir_s;
   logic [14:0]          frame_addr_s;
   logic                 bcast_s;
   logic                 wr_hit_s;
   logic                 rd_hit_s;
   logic [SF_BITS-1:0]   processed_s;
   logic [7:0]           presc_eff_s;

   // Synchronize the asynchronous serial inputs; the third clock stage gives the previous level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q <= 3'b111;
         dat_sync_q <= 2'b00;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], debug_rx_clk};
         dat_sync_q <= {dat_sync_q[0], debug_rx_data};
      end
   end

   // Decode the received frame and the local action it requests.
   always_comb begin
      rx_rise_s    = clk_sync_q[1] & ~clk_sync_q[2];
      rx_bit_s     = dat_sync_q[1];
      last_bit_s   = (bit_cnt_q == CW'(SF_BITS - 1));
      frame_dir_s  = frame_q[SF_BITS-1];
      frame_addr_s = frame_q[SF_BITS-2:BITS];
`ifdef SERIAL_DEBUG_BROADCAST_EN
      bcast_s      = (frame_addr_s == 15'h7FFF);
`else
      bcast_s      = 1'b0;
`endif
      wr_hit_s     = frame_dir_s & ((frame_addr_s == ADDRESS) | bcast_s);
      rd_hit_s     = ~frame_dir_s & (frame_addr_s == ADDRESS) & ~bcast_s;
      if (rd_hit_s) begin
         processed_s = {frame_q[SF_BITS-1:BITS], debug_in};
      end else begin
         processed_s = frame_q;
      end
      if (prescaler == 8'd0) begin
         presc_eff_s = 8'd1;
      end else begin
         presc_eff_s = prescaler;
      end
   end

   // Node FSM: receive, process for one cycle, then shift the frame out MSB first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         frame_q           <= '0;
         bit_cnt_q         <= '0;
         tx_cnt_q          <= '0;
         hp_cnt_q          <= 8'd0;
         tx_clk_q          <= 1'b1;
         tx_data_q         <= 1'b0;
         debug_out_q       <= '0;
         debug_out_valid_q <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         debug_out_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_rise_s) begin
                  frame_q   <= {frame_q[SF_BITS-2:0], rx_bit_s};
                  bit_cnt_q <= CW'(1);
                  state_q   <= ST_RX;
                  busy_q    <= 1'b1;
               end
            end
            ST_RX: begin
               if (rx_rise_s) begin
                  frame_q   <= {frame_q[SF_BITS-2:0], rx_bit_s};
                  bit_cnt_q <= bit_cnt_q + CW'(1);
                  if (last_bit_s) begin
                     state_q <= ST_PROCESS;
                  end
               end
            end
            ST_PROCESS: begin
               frame_q <= processed_s;
               if (wr_hit_s) begin
                  debug_out_q       <= frame_q[BITS-1:0];
                  debug_out_valid_q <= 1'b1;
               end
               bit_cnt_q <= '0;
               tx_cnt_q  <= '0;
               hp_cnt_q  <= presc_eff_s;
               tx_clk_q  <= 1'b1;
               state_q   <= ST_TX;
            end
            ST_TX: begin
               if (hp_cnt_q > 8'd1) begin
                  hp_cnt_q <= hp_cnt_q - 8'd1;
               end else begin
                  hp_cnt_q <= presc_eff_s;
                  if (tx_clk_q) begin
                     if (tx_cnt_q != CW'(SF_BITS)) begin
                        tx_data_q <= frame_q[SF_BITS-1];
                        frame_q   <= {frame_q[SF_BITS-2:0], 1'b0};
                        tx_cnt_q  <= tx_cnt_q + CW'(1);
                        tx_clk_q  <= 1'b0;
                     end
                  end else begin
                     tx_clk_q <= 1'b1;
                     // The rising edge just issued completes the frame once every bit has gone out.
                     if (tx_cnt_q == CW'(SF_BITS)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               tx_clk_q <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign debug_tx_data   = tx_data_q;
   assign debug_tx_clk    = tx_clk_q;
   assign debug_out       = debug_out_q;
   assign debug_out_valid = debug_out_valid_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_debug_node.sv
// Two chained debug nodes (0x0012 -> 0x0013) driven with directed and random frames,
// checked against a frame-level reference model.
module tb_debug_node;

   localparam int SF = 144;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   prescaler;
   logic         rx_data;
   logic         rx_clk;
   logic [127:0] din_a, din_b;
   logic [127:0] dout_a, dout_b;
   logic [1:0]   txd, txc, vld, bsy;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   debug_node #(.BITS(128), .ADDRESS(15'h0012)) u_a (
      .clk(clk), .rst_n(rst_n), .prescaler(prescaler),
      .debug_rx_data(rx_data), .debug_rx_clk(rx_clk),
      .debug_tx_data(txd[0]), .debug_tx_clk(txc[0]),
      .debug_in(din_a), .debug_out(dout_a), .debug_out_valid(vld[0]), .busy(bsy[0])
   );

   debug_node #(.BITS(128), .ADDRESS(15'h0013)) u_b (
      .clk(clk), .rst_n(rst_n), .prescaler(prescaler),
      .debug_rx_data(txd[0]), .debug_rx_clk(txc[0]),
      .debug_tx_data(txd[1]), .debug_tx_clk(txc[1]),
      .debug_in(din_b), .debug_out(dout_b), .debug_out_valid(vld[1]), .busy(bsy[1])
   );

   // Line monitor: collects emitted frames, valid pulses, half-period and data-stability errors.
   int           exp_hp = 4;
   logic [1:0]   prev_c = 2'b11;
   logic [1:0]   prev_d = 2'b00;
   int           edges[2]  = '{0, 0};
   int           hp[2]     = '{0, 0};
   int           hp_bad[2] = '{0, 0};
   int           stab[2]   = '{0, 0};
   int           got_n[2]  = '{0, 0};
   int           vcnt[2]   = '{0, 0};
   logic [143:0] shreg[2];
   logic [143:0] got[2];

   always @(negedge clk) begin
      logic [143:0] sh;
      int           ne;
      for (int n = 0; n < 2; n++) begin
         if (vld[n] === 1'b1) vcnt[n] <= vcnt[n] + 1;
         if (rst_n && (txd[n] !== prev_d[n]) && !(prev_c[n] && !txc[n])) stab[n] <= stab[n] + 1;
         if (txc[n] !== prev_c[n]) begin
            hp[n] <= 1;
            if (txc[n]) begin
               sh = {shreg[n][SF-2:0], txd[n]};
               ne = edges[n] + 1;
               if (hp[n] != exp_hp) hp_bad[n] <= hp_bad[n] + 1;
               if (ne == SF) begin
                  got[n]   <= sh;
                  got_n[n] <= got_n[n] + 1;
                  ne = 0;
               end
               shreg[n] <= sh;
               edges[n] <= ne;
            end else if (edges[n] != 0 && hp[n] != exp_hp) begin
               hp_bad[n] <= hp_bad[n] + 1;
            end
         end else begin
            hp[n] <= hp[n] + 1;
         end
         prev_c[n] <= txc[n];
         prev_d[n] <= txd[n];
      end
   end

   task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: what one node does to a frame (forwarded frame, and whether it writes locally).
   function automatic logic [143:0] node_fwd(input logic [143:0] f, input logic [14:0] adr,
                                            input logic [127:0] din, output logic wr);
      logic        dir;
      logic [14:0] a;
      logic        bc;
      dir = f[143];
      a   = f[142:128];
      bc  = 1'b0;
`ifdef SERIAL_DEBUG_BROADCAST_EN
      bc  = (a == 15'h7FFF);
`endif
      wr = 1'b0;
      node_fwd = f;
      if (dir && (a == adr || bc)) wr = 1'b1;
      else if (!dir && a == adr && !bc) node_fwd = {f[143:128], din};
   endfunction

   task automatic send_bits(input logic [143:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         rx_clk  = 1'b0;
         rx_data = f[SF-1-i];
         repeat (3) @(negedge clk);
         rx_clk = 1'b1;
         repeat (2) @(negedge clk);
      end
   endtask

   logic [127:0] exp_a = '0;
   logic [127:0] exp_b = '0;

   task automatic run_frame(input string tag, input logic [143:0] f);
      logic [143:0] fa, fb;
      logic         wa, wb;
      int ga, gb, va, vb, ha, hb, sa, sb, t;
      fa = node_fwd(f, 15'h0012, din_a, wa);
      fb = node_fwd(fa, 15'h0013, din_b, wb);
      ga = got_n[0]; gb = got_n[1];
      va = vcnt[0];  vb = vcnt[1];
      ha = hp_bad[0]; hb = hp_bad[1];
      sa = stab[0];  sb = stab[1];
      exp_hp = (prescaler == 8'd0) ? 1 : int'(prescaler);
      send_bits(f, SF);
      repeat (6) @(negedge clk);
      check({tag, " busy_a"}, 144'(bsy[0]), 144'd1);
      t = 0;
      while (got_n[1] == gb && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check({tag, " timeout"}, 144'(t < 20000), 144'd1);
      repeat (10) @(negedge clk);
      if (wa) exp_a = f[127:0];
      if (wb) exp_b = fa[127:0];
      check({tag, " nframes_a"}, 144'(got_n[0] - ga), 144'd1);
      check({tag, " frame_a"}, got[0], fa);
      check({tag, " nframes_b"}, 144'(got_n[1] - gb), 144'd1);
      check({tag, " frame_b"}, got[1], fb);
      check({tag, " valid_a"}, 144'(vcnt[0] - va), 144'(wa));
      check({tag, " valid_b"}, 144'(vcnt[1] - vb), 144'(wb));
      check({tag, " dout_a"}, 144'(dout_a), 144'(exp_a));
      check({tag, " dout_b"}, 144'(dout_b), 144'(exp_b));
      check({tag, " halfper"}, 144'(hp_bad[0] - ha + hp_bad[1] - hb), 144'd0);
      check({tag, " stable"}, 144'(stab[0] - sa + stab[1] - sb), 144'd0);
      check({tag, " leftover_edges"}, 144'(edges[0] + edges[1]), 144'd0);
      check({tag, " idle"}, 144'({bsy, txc}), 144'(4'b0011));
   endtask

   initial begin
      logic [14:0]  atab [4];
      logic [143:0] f;
      atab = '{15'h0012, 15'h0013, 15'h0014, 15'h7FFF};
      rst_n = 1'b0; prescaler = 8'd4; rx_data = 1'b0; rx_clk = 1'b1;
      din_a = '0; din_b = '0;
      repeat (5) @(negedge clk);
      check("rst tx_clk", 144'(txc), 144'(2'b11));
      check("rst tx_data", 144'(txd), 144'd0);
      check("rst valid", 144'(vld), 144'd0);
      check("rst busy", 144'(bsy), 144'd0);
      check("rst dout", {16'd0, dout_a | dout_b}, 144'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      run_frame("wr12", {1'b1, 15'h0012, 128'hDEADBEEF_00000000_00000000_00000001});
      din_a = {16{8'hA5}};
      din_b = {4{32'h1234_5678}};
      run_frame("rd12", {1'b1 ^ 1'b1, 15'h0012, 128'h0});
      run_frame("wr13", {1'b1, 15'h0013, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
      run_frame("rd13", {1'b0, 15'h0013, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});

      for (int k = 0; k < 4; k++) begin
         prescaler = 8'($urandom_range(0, 3));
         din_a = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         din_b = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         f = {1'($urandom), atab[$urandom_range(0, 3)],
              32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         run_frame("rand", f);
      end

      // Partial frame abandoned by reset, then a complete write.
      prescaler = 8'd2;
      f = {1'b1, 15'h0012, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
      send_bits(f, 70);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrx busy", 144'(bsy), 144'd0);
      check("midrx dout", {16'd0, dout_a | dout_b}, 144'd0);
      rst_n = 1'b1;
      exp_a = '0; exp_b = '0;
      repeat (3) @(negedge clk);
      run_frame("after_rst", f);

      prescaler = 8'd0;
      run_frame("bcast", {1'b1, 15'h7FFF, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
